// File: rtl/inv_cipher_ctrl.sv
// ----------------------------------------------------------------------------
// inv_cipher_ctrl
// Sequencer for the AES-128 inverse cipher datapath. After an accepted start
// it steps the state register through the initial AddRoundKey, NR-1 full
// inverse rounds (InvShiftRows+InvSubBytes, AddRoundKey, InvMixColumns) and
// the final inverse round, one datapath step per clock.
//
// Optional feature: define AES_DEC_KEY_WAIT_EN to stall the AddRoundKey steps
// until key_ready is high. Without it, key_ready is ignored and the latency is
// fixed at 3*NR step cycles.
//
// Ports
//   clk        in   system clock, rising edge
//   n_rst      in   asynchronous active-low reset
//   start      in   decryption request, accepted in IDLE or DONE only
//   clear      in   synchronous abort back to IDLE
//   key_ready  in   round key at key_idx is valid (key-wait builds only)
//   load_in    out  capture ciphertext into the state register this cycle
//   state_we   out  write the selected step result into the state register
//   step_sel   out  00 none, 01 InvShiftRows+InvSubBytes, 10 ARK, 11 InvMixCol
//   key_idx    out  round-key index for AddRoundKey
//   busy       out  sequence in progress
//   done       out  one-cycle pulse, state register holds plaintext
// ----------------------------------------------------------------------------
module inv_cipher_ctrl #(
  parameter int unsigned NR = 10
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  input  logic       clear,
  input  logic       key_ready,
  output logic       load_in,
  output logic       state_we,
  output logic [1:0] step_sel,
  output logic [3:0] key_idx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned RND_W  = 4;
  localparam int unsigned STEP_W = 2;

  localparam logic [STEP_W-1:0] STEP_NONE = 2'b00;
  localparam logic [STEP_W-1:0] STEP_ROW  = 2'b01;
  localparam logic [STEP_W-1:0] STEP_ARK  = 2'b10;
  localparam logic [STEP_W-1:0] STEP_MIX  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARK0 = 3'd1,
    S_ROW  = 3'd2,
    S_ARK  = 3'd3,
    S_MIX  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [RND_W-1:0] r_rnd;
  logic [RND_W-1:0] w_rnd_nxt;
  logic [RND_W-1:0] r_key_idx;
  logic [RND_W-1:0] w_key_nxt;
  logic             w_key_ok;

  // Key availability gate for the AddRoundKey steps.
`ifdef AES_DEC_KEY_WAIT_EN
  assign w_key_ok = key_ready;
`else
  logic w_unused_key_ready;
  assign w_unused_key_ready = key_ready;
  assign w_key_ok           = 1'b1;
`endif

  // State, round counter and held key index registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= S_IDLE;
      r_rnd     <= '0;
      r_key_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rnd     <= w_rnd_nxt;
      r_key_idx <= w_key_nxt;
    end
  end

  // Next-state and output decode. key_idx is registered from the next state,
  // so it is already valid in the ARK0/ARK cycle and holds in between.
  always_comb begin
    w_state_nxt = r_state;
    w_rnd_nxt   = r_rnd;
    w_key_nxt   = r_key_idx;
    load_in     = 1'b0;
    state_we    = 1'b0;
    step_sel    = STEP_NONE;
    busy        = 1'b0;
    done        = 1'b0;

    case (r_state)
      S_IDLE, S_DONE: begin
        done    = (r_state == S_DONE);
        load_in = start;
        if (start) begin
          w_state_nxt = S_ARK0;
          w_rnd_nxt   = RND_W'(NR);
          w_key_nxt   = RND_W'(NR);
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ARK0: begin
        busy     = 1'b1;
        step_sel = STEP_ARK;
        state_we = w_key_ok;
        if (w_key_ok) begin
          w_state_nxt = S_ROW;
          w_rnd_nxt   = RND_W'(NR - 1);
        end
      end
      S_ROW: begin
        busy        = 1'b1;
        step_sel    = STEP_ROW;
        state_we    = 1'b1;
        w_state_nxt = S_ARK;
        w_key_nxt   = r_rnd;
      end
      S_ARK: begin
        busy     = 1'b1;
        step_sel = STEP_ARK;
        state_we = w_key_ok;
        if (w_key_ok) begin
          w_state_nxt = (r_rnd == '0) ? S_DONE : S_MIX;
        end
      end
      S_MIX: begin
        busy        = 1'b1;
        step_sel    = STEP_MIX;
        state_we    = 1'b1;
        w_state_nxt = S_ROW;
        w_rnd_nxt   = r_rnd - RND_W'(1);
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_rnd_nxt   = '0;
        w_key_nxt   = '0;
      end
    endcase

    // Abort wins over everything but reset; no writes in the abort cycle.
    if (clear) begin
      w_state_nxt = S_IDLE;
      w_rnd_nxt   = '0;
      w_key_nxt   = '0;
      state_we    = 1'b0;
      load_in     = 1'b0;
    end
  end

  assign key_idx = r_key_idx;

endmodule

// File: tb/tb_inv_cipher_ctrl.sv
// ----------------------------------------------------------------------------
// tb_inv_cipher_ctrl
// Directed bench for inv_cipher_ctrl with NR=10. Expected outputs per cycle
// after start come from a small hand-derived table of the step schedule:
// cycle 1 ARK0, then (ROW, ARK, MIX) repeating, last ARK in cycle 30, DONE 31.
// ----------------------------------------------------------------------------
module tb_inv_cipher_ctrl;

  logic       clk;
  logic       n_rst;
  logic       start;
  logic       clear;
  logic       key_ready;
  logic       load_in;
  logic       state_we;
  logic [1:0] step_sel;
  logic [3:0] key_idx;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  inv_cipher_ctrl #(.NR(10)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .clear     (clear),
    .key_ready (key_ready),
    .load_in   (load_in),
    .state_we  (state_we),
    .step_sel  (step_sel),
    .key_idx   (key_idx),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are driven 2 time units after the rising edge, checks 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".we"},   32'(state_we), 32'd0);
    chk({tag, ".step"}, 32'(step_sel), 32'd0);
    chk({tag, ".key"},  32'(key_idx),  32'd0);
    chk({tag, ".busy"}, 32'(busy),     32'd0);
    chk({tag, ".done"}, 32'(done),     32'd0);
  endtask

  // Expected outputs for cycle c (1..31) after an accepted start.
  task automatic check_cycle(input string tag, input int c, input logic exp_load);
    logic [1:0] e_step;
    logic [3:0] e_key;
    logic       e_we, e_busy, e_done;
    int k;
    if (c == 31) begin
      e_step = 2'b00; e_key = 4'd0; e_we = 1'b0; e_busy = 1'b0; e_done = 1'b1;
    end else if (c == 1) begin
      e_step = 2'b10; e_key = 4'd10; e_we = 1'b1; e_busy = 1'b1; e_done = 1'b0;
    end else begin
      k = c - 2;
      e_we = 1'b1; e_busy = 1'b1; e_done = 1'b0;
      case (k % 3)
        0:       begin e_step = 2'b01; e_key = 4'(10 - k / 3); end
        1:       begin e_step = 2'b10; e_key = 4'(9 - k / 3);  end
        default: begin e_step = 2'b11; e_key = 4'(9 - k / 3);  end
      endcase
    end
    chk($sformatf("%s.c%0d.we", tag, c),   32'(state_we), 32'(e_we));
    chk($sformatf("%s.c%0d.step", tag, c), 32'(step_sel), 32'(e_step));
    chk($sformatf("%s.c%0d.key", tag, c),  32'(key_idx),  32'(e_key));
    chk($sformatf("%s.c%0d.busy", tag, c), 32'(busy),     32'(e_busy));
    chk($sformatf("%s.c%0d.done", tag, c), 32'(done),     32'(e_done));
    chk($sformatf("%s.c%0d.load", tag, c), 32'(load_in),  32'(exp_load));
  endtask

  // Single start pulse, optional stray start pulse in cycle pulse_c.
  task automatic run_op(input string tag, input int pulse_c);
    start = 1'b1;
    #1;
    chk({tag, ".load_e0"}, 32'(load_in), 32'd1);
    for (int c = 1; c <= 31; c++) begin
      tick();
      start = (c == pulse_c);
      #1;
      check_cycle(tag, c, 1'b0);
    end
    start = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0;
    start = 1'b0;
    clear = 1'b0;
`ifdef AES_DEC_KEY_WAIT_EN
    key_ready = 1'b1;
`else
    key_ready = 1'b0;
`endif

    // Reset values.
    #12;
    chk("rst.load", 32'(load_in), 32'd0);
    chk_idle("rst");
    n_rst = 1'b1;
    tick();
    #1;
    chk_idle("idle");

    // Plain operation (key_ready is ignored unless key wait is built in).
    tick();
    run_op("run1", 0);
    tick();
    #1;
    chk_idle("run1.after");

    // Start held: second op starts straight out of DONE.
    start = 1'b1;
    for (int c = 1; c <= 31; c++) begin
      tick();
      #1;
      check_cycle("hold", c, c == 31);
    end
    tick();
    #1;
    check_cycle("hold2", 1, 1'b0);
    start = 1'b0;
    for (int c = 2; c <= 31; c++) begin
      tick();
      #1;
      check_cycle("hold2", c, 1'b0);
    end
    tick();
    #1;
    chk_idle("hold2.after");

    // Stray start during a ROW step (cycle 14) is ignored.
    run_op("stray", 14);
    tick();
    #1;
    chk_idle("stray.after");

    // Clear in the MIX step of cycle 10.
    start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      start = 1'b0;
      #1;
      check_cycle("clr", c, 1'b0);
    end
    clear = 1'b1;
    #1;
    chk("clr.we_in_clear", 32'(state_we), 32'd0);
    chk("clr.step_in_clear", 32'(step_sel), 32'd3);
    tick();
    clear = 1'b0;
    #1;
    chk_idle("clr.next");
    for (int c = 0; c < 25; c++) begin
      tick();
      #1;
      chk($sformatf("clr.nodone%0d", c), 32'(done), 32'd0);
    end

    // Reset dropped in cycle 12, then a fresh full run.
    start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      start = 1'b0;
      #1;
      check_cycle("arst", c, 1'b0);
    end
    n_rst = 1'b0;
    #1;
    chk("arst.load", 32'(load_in), 32'd0);
    chk_idle("arst.async");
    tick();
    n_rst = 1'b1;
    #1;
    chk_idle("arst.rel");
    tick();
    run_op("arst.run", 0);

`ifdef AES_DEC_KEY_WAIT_EN
    // key_ready low for 3 cycles at the ARK with key_idx 7 (cycle 9).
    tick();
    start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      start = 1'b0;
      #1;
      check_cycle("kw", c, 1'b0);
    end
    for (int s = 0; s < 3; s++) begin
      tick();
      key_ready = 1'b0;
      #1;
      chk($sformatf("kw.stall%0d.we", s),   32'(state_we), 32'd0);
      chk($sformatf("kw.stall%0d.key", s),  32'(key_idx),  32'd7);
      chk($sformatf("kw.stall%0d.step", s), 32'(step_sel), 32'd2);
      chk($sformatf("kw.stall%0d.busy", s), 32'(busy),     32'd1);
    end
    for (int c = 9; c <= 31; c++) begin
      tick();
      key_ready = 1'b1;
      #1;
      check_cycle("kw", c, 1'b0);
    end
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inv_cipher_ctrl.md
# inv_cipher_ctrl

Sequencer for the AES-128 decryption datapath. On `start`, it walks the state register through the initial AddRoundKey, NR-1 full inverse rounds (InvShiftRows+InvSubBytes, AddRoundKey, InvMixColumns) and the final inverse round, one datapath step per clock. It drives the step-select mux, state-register write enable, input load and round-key index. It sits between the decryption top level and the combinational inverse-round primitives.

## Interface
- `NR`, 10, number of cipher rounds; round-key index counts NR down to 0
- `clk`  in  1  system clock, rising edge
- `n_rst`  in  1  asynchronous active-low reset
- `start`  in  1  request a decryption; accepted only in IDLE or DONE
- `clear`  in  1  synchronous abort; returns to IDLE next edge, overrides everything except reset
- `key_ready`  in  1  round key at `key_idx` valid (used only with AES_DEC_KEY_WAIT_EN)
- `load_in`  out  1  capture ciphertext into state register this cycle
- `state_we`  out  1  write selected step result into state register
- `step_sel`  out  2  00 none, 01 InvShiftRows+InvSubBytes, 10 AddRoundKey, 11 InvMixColumns
- `key_idx`  out  4  round-key index for AddRoundKey
- `busy`  out  1  sequence in progress
- `done`  out  1  one-cycle pulse: state register holds plaintext

## Operation
- States: IDLE, ARK0, ROW, ARK, MIX, DONE. Round counter `rnd` 4 bits.
- IDLE/DONE: `load_in = start & ~clear`, combinational. On an accepted start, the next state is ARK0 and `rnd` is set to NR.
- ARK0: step 10, `key_idx=NR`, `state_we=1`. The next state is ROW and `rnd` becomes NR-1.
- ROW: step 01, `state_we=1`. The next state is ARK.
- ARK: step 10, `key_idx=rnd`, `state_we=1`. If `rnd==0`, the next state is DONE. Otherwise the next state is MIX.
- MIX: step 11, `state_we=1`. The next state is ROW and `rnd` decrements.
- DONE: `done=1`, `busy=0`, `state_we=0`. With no start, the next state is IDLE. With a start, it behaves as IDLE, which allows back-to-back operations.
- `busy=1` in ARK0, ROW, ARK and MIX. `busy=0` in IDLE and DONE.
- A start arriving while busy is ignored and is not queued.
- `clear`: from any state, the next state is IDLE. No `done` is generated. `state_we` and `load_in` are 0 in the cycle `clear` is high.
- `key_idx` outside ARK0/ARK holds its last value. It is 0 after reset or clear.
- Reset mid-operation: all outputs return to reset values immediately.

## Timing
- Reset values: `load_in=0`, `state_we=0`, `step_sel=00`, `key_idx=0`, `busy=0`, `done=0`. State is IDLE and `rnd=0`.
- Start accepted at edge E0 (IDLE). The ARK0 cycle follows E0.
- Step cycles total 3*NR, which is 30 for NR=10.
- `done` is high in cycle 3*NR+1 after E0 (cycle 31 for NR=10).
- Outputs other than `load_in` are Moore outputs decoded from the registered state/`rnd`.
- Key index sequence seen on ARK steps: NR, NR-1, ..., 1, 0.

## Configuration
- `AES_DEC_KEY_WAIT_EN` defined:
  - In ARK0/ARK with `key_ready=0`, state and `rnd` hold.
  - `state_we=0`, while `step_sel` and `key_idx` stay driven.
  - The step completes on the first cycle with `key_ready=1`.
  - Latency grows by one cycle per stalled cycle.
- Not defined: `key_ready` is ignored and latency is fixed at 3*NR.

## Test plan
- Reset, then a single start pulse with NR=10:
  - `busy` rises the next cycle.
  - Exactly 30 `state_we` cycles occur, with step pattern 10,(01,10,11)x9,01,10.
  - `key_idx` on ARK steps is 10..0.
  - `done` occurs at cycle 31.
- Start held high continuously:
  - `load_in` occurs in the DONE cycle.
  - The next ARK0 begins immediately, with no IDLE cycle between operations.
- Start pulsed during ROW of round 5: no effect; `done` still arrives at cycle 31.
- `clear` asserted in MIX of round 3:
  - IDLE is reached the next edge and `busy=0`.
  - No `done` is generated.
  - `key_idx=0`.
- `n_rst` dropped in cycle 12: all outputs go to reset values asynchronously, and a fresh start after release yields a full 30-cycle run.
- With AES_DEC_KEY_WAIT_EN, `key_ready=0` for 3 cycles at the ARK with `key_idx=7`:
  - `state_we` is low for those cycles while `key_idx` holds at 7.
  - `done` arrives at cycle 34.
